// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel_stream edge detector.
//   state_e       : FILL / RUN / FLUSH sequencing of the stream engine
//   K_OUTER/K_CENTER : 1-2-1 smoothing weights used by both Sobel kernels
//   GRAD_HEADROOM : extra bits a signed gradient needs above the pixel width
//   grad_w()      : gradient width GRAD_W = PIX_W + GRAD_HEADROOM
package sobel_pkg;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } state_e;

    localparam int K_OUTER  = 1;
    localparam int K_CENTER = 2;

    localparam int unsigned GRAD_HEADROOM = 4;

    function automatic int unsigned grad_w(input int unsigned pix_w);
        return pix_w + GRAD_HEADROOM;
    endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// Pixel-in / edge-out stream bundle for sobel_stream.
//   threshold, in_valid, in_ready, in_pixel     : input pixel stream
//   out_valid, out_ready, out_edge, out_eol,
//   out_eof, out_mag                            : output beat stream
// out_mag exists only when SOBEL_MAG_OUT_EN is defined.
// Modports: master = stream source/sink (test or upstream), slave = detector.
interface sobel_stream_if #(
    parameter int unsigned PIX_W = 8
);
    logic [PIX_W-1:0] threshold;
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic             out_edge;
    logic             out_eol;
    logic             out_eof;
`ifdef SOBEL_MAG_OUT_EN
    logic [PIX_W-1:0] out_mag;
`endif

    modport master (
        output threshold, in_valid, in_pixel, out_ready,
`ifdef SOBEL_MAG_OUT_EN
        input  out_mag,
`endif
        input  in_ready, out_valid, out_edge, out_eol, out_eof
    );

    modport slave (
        input  threshold, in_valid, in_pixel, out_ready,
`ifdef SOBEL_MAG_OUT_EN
        output out_mag,
`endif
        output in_ready, out_valid, out_edge, out_eol, out_eof
    );

endinterface

// File: rtl/sobel_linebuf.sv
// DEPTH-sample delay line: each enabled cycle writes din and presents the
// sample written DEPTH enables earlier on dout.
//   clk, rst_n : clock, synchronous active-low reset (pointer only)
//   en         : advance the line by one sample
//   din / dout : sample in / sample delayed by DEPTH enables
// Storage contents are never reset.
module sobel_linebuf #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);
    localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr_q, ptr_d;

    // Read-before-write on the same slot yields the DEPTH-old sample.
    assign dout = mem[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector, raster order, one output beat per pixel.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : sobel_stream_if.slave
//                in : threshold, in_valid, in_pixel, out_ready
//                out: in_ready, out_valid, out_edge, out_eol, out_eof,
//                     out_mag (only with SOBEL_MAG_OUT_EN)
// Optional feature macro: SOBEL_MAG_OUT_EN adds the saturated magnitude port.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned PIX_W      = 8
) (
    input logic           clk,
    input logic           rst_n,
    sobel_stream_if.slave bus
);
    localparam int unsigned       GRAD_W  = grad_w(PIX_W);
    localparam int unsigned       XW      = $clog2(IMG_WIDTH);
    localparam int unsigned       YW      = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0]     X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST  = YW'(IMG_HEIGHT - 1);
    localparam logic [GRAD_W-1:0] MAG_MAX = GRAD_W'((1 << PIX_W) - 1);

    state_e           state_q, state_d;
    logic             ready_en_q, ready_en_d;
    logic [XW-1:0]    in_x_q, in_x_d, gen_x_q, gen_x_d;
    logic [YW-1:0]    in_y_q, in_y_d, gen_y_q, gen_y_d;
    logic [PIX_W-1:0] thr_q, thr_d;
    logic             out_valid_q, out_valid_d;
    logic             out_edge_q, out_edge_d;
    logic             out_eol_q, out_eol_d;
    logic             out_eof_q, out_eof_d;
`ifdef SOBEL_MAG_OUT_EN
    logic [PIX_W-1:0] out_mag_q, out_mag_d;
`endif

    // Window: left/mid columns are registered, the right column is live.
    // Index 0 = two lines up, 1 = one line up, 2 = incoming line.
    logic [PIX_W-1:0] left_q [3], left_d [3];
    logic [PIX_W-1:0] mid_q  [3], mid_d  [3];
    logic [PIX_W-1:0] col_new [3];
    logic [PIX_W-1:0] lb1_dout, lb2_dout;

    logic                     in_ready, in_fire, out_fire, load, border;
    logic signed [GRAD_W-1:0] gx, gy;
    logic [GRAD_W-1:0]        abs_x, abs_y, mag_full;
    logic [PIX_W-1:0]         mag_sat;

    function automatic logic signed [GRAD_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                                      input logic [PIX_W-1:0] b,
                                                      input logic [PIX_W-1:0] c);
        return GRAD_W'(K_OUTER * int'(a) + K_CENTER * int'(b) + K_OUTER * int'(c));
    endfunction

    sobel_linebuf #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb1 (
        .clk(clk), .rst_n(rst_n), .en(in_fire), .din(bus.in_pixel), .dout(lb1_dout)
    );

    sobel_linebuf #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb2 (
        .clk(clk), .rst_n(rst_n), .en(in_fire), .din(lb1_dout), .dout(lb2_dout)
    );

    // ready_en_q keeps in_ready low until the first cycle after reset releases.
    assign in_ready      = ready_en_q && (state_q != FLUSH) && (!out_valid_q || bus.out_ready);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_edge  = out_edge_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.out_eof   = out_eof_q;
`ifdef SOBEL_MAG_OUT_EN
    assign bus.out_mag   = out_mag_q;
`endif

    always_comb begin
        in_fire  = bus.in_valid && in_ready;
        out_fire = out_valid_q && bus.out_ready;

        col_new[0] = lb2_dout;
        col_new[1] = lb1_dout;
        col_new[2] = bus.in_pixel;

        gx       = wsum(col_new[0], col_new[1], col_new[2]) - wsum(left_q[0], left_q[1], left_q[2]);
        gy       = wsum(left_q[2], mid_q[2], col_new[2]) - wsum(left_q[0], mid_q[0], col_new[0]);
        abs_x    = gx[GRAD_W-1] ? GRAD_W'(-gx) : GRAD_W'(gx);
        abs_y    = gy[GRAD_W-1] ? GRAD_W'(-gy) : GRAD_W'(gy);
        mag_full = abs_x + abs_y;
        mag_sat  = (mag_full > MAG_MAX) ? '1 : mag_full[PIX_W-1:0];
        border   = (gen_x_q == '0) || (gen_x_q == X_LAST) || (gen_y_q == '0) || (gen_y_q == Y_LAST);

        state_d    = state_q;
        ready_en_d = 1'b1;
        load       = 1'b0;
        // Input index W is the last FILL pixel; in RUN each accepted pixel
        // completes the window centred W+1 positions behind it.  The W+1
        // positions left after the final pixel are all border beats, so
        // FLUSH emits them without new input.
        case (state_q)
            FILL: begin
                if (in_fire && (in_x_q == '0) && (in_y_q == YW'(1))) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                load = in_fire;
                if (in_fire && (in_x_q == X_LAST) && (in_y_q == Y_LAST)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                load = (!out_valid_q || bus.out_ready) && !(out_valid_q && out_eof_q);
                if (out_fire && out_eof_q) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        in_x_d = in_x_q;
        in_y_d = in_y_q;
        thr_d  = thr_q;
        left_d = left_q;
        mid_d  = mid_q;
        if (in_fire) begin
            in_x_d = (in_x_q == X_LAST) ? '0 : in_x_q + 1'b1;
            if (in_x_q == X_LAST) begin
                in_y_d = (in_y_q == Y_LAST) ? '0 : in_y_q + 1'b1;
            end
            if ((state_q == FILL) && (in_x_q == '0) && (in_y_q == '0)) begin
                thr_d = bus.threshold;
            end
            left_d = mid_q;
            mid_d  = col_new;
        end

        gen_x_d     = gen_x_q;
        gen_y_d     = gen_y_q;
        out_valid_d = out_valid_q;
        out_edge_d  = out_edge_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
`ifdef SOBEL_MAG_OUT_EN
        out_mag_d   = out_mag_q;
`endif
        if (load) begin
            out_valid_d = 1'b1;
            out_edge_d  = !border && (mag_sat > thr_q);
            out_eol_d   = (gen_x_q == X_LAST);
            out_eof_d   = (gen_x_q == X_LAST) && (gen_y_q == Y_LAST);
`ifdef SOBEL_MAG_OUT_EN
            out_mag_d   = border ? '0 : mag_sat;
`endif
            gen_x_d = (gen_x_q == X_LAST) ? '0 : gen_x_q + 1'b1;
            if (gen_x_q == X_LAST) begin
                gen_y_d = (gen_y_q == Y_LAST) ? '0 : gen_y_q + 1'b1;
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            ready_en_q  <= 1'b0;
            in_x_q      <= '0;
            in_y_q      <= '0;
            gen_x_q     <= '0;
            gen_y_q     <= '0;
            thr_q       <= '0;
            out_valid_q <= 1'b0;
            out_edge_q  <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
`ifdef SOBEL_MAG_OUT_EN
            out_mag_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ready_en_q  <= ready_en_d;
            in_x_q      <= in_x_d;
            in_y_q      <= in_y_d;
            gen_x_q     <= gen_x_d;
            gen_y_q     <= gen_y_d;
            thr_q       <= thr_d;
            out_valid_q <= out_valid_d;
            out_edge_q  <= out_edge_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
`ifdef SOBEL_MAG_OUT_EN
            out_mag_q   <= out_mag_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        left_q <= left_d;
        mid_q  <= mid_d;
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream on an 8x6 frame. Expected beats come
// from a direct 3x3 convolution model over the stored image.
module tb_sobel_stream;
    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;
`ifdef SOBEL_MAG_OUT_EN
    localparam bit HAS_MAG = 1'b1;
`else
    localparam bit HAS_MAG = 1'b0;
`endif

    typedef logic [10:0] beat_t; // {edge, eol, eof, mag}

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   stall_viol;
    int   stall_seen;

    beat_t      got[$];
    beat_t      exp_q[$];
    logic [7:0] imgs [2][N];

    sobel_stream_if #(.PIX_W(8)) bus ();

    sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic beat_t sample_beat();
`ifdef SOBEL_MAG_OUT_EN
        return {bus.out_edge, bus.out_eol, bus.out_eof, bus.out_mag};
`else
        return {bus.out_edge, bus.out_eol, bus.out_eof, 8'h00};
`endif
    endfunction

    // kind 0: flat 77, 1: step 0|200 at x=4, 2: random 0..31
    task automatic set_image(input int f, input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       imgs[f][i] = 8'd77;
                1:       imgs[f][i] = ((i % W) < 4) ? 8'd0 : 8'd200;
                default: imgs[f][i] = 8'($urandom_range(0, 31));
            endcase
        end
    endtask

    function automatic void model_frame(input int f, input int thr);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int   gx, gy, mag;
                logic e;
                gx = 0; gy = 0; mag = 0;
                if (x > 0 && x < W - 1 && y > 0 && y < H - 1) begin
                    for (int d = -1; d <= 1; d++) begin
                        int wt;
                        wt = (d == 0) ? 2 : 1;
                        gx += wt * (int'(imgs[f][(y + d) * W + x + 1]) - int'(imgs[f][(y + d) * W + x - 1]));
                        gy += wt * (int'(imgs[f][(y + 1) * W + x + d]) - int'(imgs[f][(y - 1) * W + x + d]));
                    end
                    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                    if (mag > 255) mag = 255;
                end
                e = (mag > thr);
                exp_q.push_back({e, x == W - 1, (x == W - 1) && (y == H - 1), HAS_MAG ? 8'(mag) : 8'h00});
            end
        end
    endfunction

    // Streams nfr frames from imgs; threshold is thr_a for pixels 0..19 of
    // the sequence and thr_b afterwards. Collects beats into got.
    task automatic run_frames(input int nfr, input logic [7:0] thr_a, input logic [7:0] thr_b, input bit rnd);
        got.delete();
        stall_viol = 0;
        stall_seen = 0;
        fork
            begin : feeder
                int i   = 0;
                int cyc = 0;
                while (i < nfr * N && cyc < 3000) begin
                    @(posedge clk); #1;
                    bus.in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    bus.in_pixel  = imgs[i / N][i % N];
                    bus.threshold = (i >= 20) ? thr_b : thr_a;
                    @(negedge clk);
                    if (bus.in_valid && bus.in_ready) i++;
                    cyc++;
                end
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
            end
            begin : sink
                int    eofs = 0;
                int    cyc  = 0;
                bit    held = 1'b0;
                beat_t hold_w;
                beat_t cur;
                while (eofs < nfr && cyc < 3000) begin
                    @(posedge clk); #1;
                    bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    @(negedge clk);
                    cur = sample_beat();
                    if (held) begin
                        stall_seen++;
                        if (cur !== hold_w) stall_viol++;
                    end
                    held = 1'b0;
                    if (bus.out_valid) begin
                        if (bus.out_ready) begin
                            got.push_back(cur);
                            if (bus.out_eof) eofs++;
                        end else begin
                            held   = 1'b1;
                            hold_w = cur;
                        end
                    end
                    cyc++;
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b0;
            end
        join
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_pixel = '0; bus.threshold = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        checks++;
        if (sample_beat() !== 11'd0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got valid=%b beat=0x%03h expected 0/0x000", bus.out_valid, sample_beat());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL release_in_ready_early: got %b expected 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_flat();
        set_image(0, 0);
        exp_q.delete();
        model_frame(0, 10);
        run_frames(1, 8'd10, 8'd10, 1'b0);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL flat_count: got %0d beats expected %0d", got.size(), exp_q.size());
        end
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                errors++; $display("FAIL flat_beat[%0d]: got 0x%03h expected 0x%03h", k, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_step();
        set_image(0, 1);
        exp_q.delete();
        model_frame(0, 100);
        run_frames(1, 8'd100, 8'd100, 1'b0);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL step_count: got %0d beats expected %0d", got.size(), exp_q.size());
        end
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                errors++; $display("FAIL step_beat[%0d]: got 0x%03h expected 0x%03h", k, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_step_saturate();
        set_image(0, 1);
        exp_q.delete();
        model_frame(0, 255);
        run_frames(1, 8'd255, 8'd255, 1'b0);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL sat_count: got %0d beats expected %0d", got.size(), exp_q.size());
        end
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                errors++; $display("FAIL sat_beat[%0d]: got 0x%03h expected 0x%03h", k, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        set_image(0, 1);
        exp_q.delete();
        model_frame(0, 100);
        run_frames(1, 8'd100, 8'd100, 1'b1);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL bp_count: got %0d beats expected %0d", got.size(), exp_q.size());
        end
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                errors++; $display("FAIL bp_beat[%0d]: got 0x%03h expected 0x%03h", k, got[k], exp_q[k]);
            end
        end
        checks++;
        if (stall_seen == 0 || stall_viol != 0) begin
            errors++; $display("FAIL bp_stall_stable: got %0d unstable of %0d stalls expected 0 of >0", stall_viol, stall_seen);
        end
    endtask

    task automatic test_random_image();
        int thr;
        thr = $urandom_range(0, 120);
        set_image(0, 2);
        exp_q.delete();
        model_frame(0, thr);
        run_frames(1, 8'(thr), 8'(thr), 1'b1);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d beats expected %0d", got.size(), exp_q.size());
        end
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                errors++; $display("FAIL rand_beat[%0d]: got 0x%03h expected 0x%03h", k, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            bus.in_pixel  = 8'($urandom);
            bus.threshold = 8'd0;
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL midreset_clear: got valid=%b ready=%b expected 0/0", bus.out_valid, bus.in_ready);
        end
        set_image(0, 1);
        exp_q.delete();
        model_frame(0, 100);
        run_frames(1, 8'd100, 8'd100, 1'b0);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL midreset_count: got %0d beats expected %0d", got.size(), exp_q.size());
        end
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                errors++; $display("FAIL midreset_beat[%0d]: got 0x%03h expected 0x%03h", k, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_image(0, 2);
        set_image(1, 2);
        exp_q.delete();
        model_frame(0, 20);
        model_frame(1, 60);
        run_frames(2, 8'd20, 8'd60, 1'b0);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count: got %0d beats expected %0d", got.size(), exp_q.size());
        end
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                errors++; $display("FAIL b2b_beat[%0d]: got 0x%03h expected 0x%03h", k, got[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_pixel  = '0;
        bus.threshold = '0;
        test_reset();
        test_flat();
        test_step();
        test_step_saturate();
        test_backpressure();
        test_random_image();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 Parameter IMG_WIDTH, default 640: pixels per line; legal range 3..4096.
REQ-002 Parameter IMG_HEIGHT, default 480: lines per frame; legal range 3..4096.
REQ-003 Parameter PIX_W, default 8: pixel and threshold width in bits.
REQ-004 clk  in  1: single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1: reset, synchronous, active-low.
REQ-006 threshold  in  PIX_W: edge threshold, sampled on the first input pixel of each frame and held for that frame.
REQ-007 in_valid  in  1: in_pixel is valid.
REQ-008 in_ready  out  1: block accepts in_pixel this cycle.
REQ-009 in_pixel  in  PIX_W: greyscale pixel, raster order starting at (0,0).
REQ-010 out_valid  out  1: output beat is valid.
REQ-011 out_ready  in  1: downstream accepts the output beat.
REQ-012 out_edge  out  1: 1 when the magnitude is strictly greater than the frame threshold.
REQ-013 out_eol  out  1: beat is the last pixel of a line.
REQ-014 out_eof  out  1: beat is the last pixel of the frame.
REQ-015 out_mag  out  PIX_W: saturated gradient magnitude; present only with SOBEL_MAG_OUT_EN.

Function
REQ-016 An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-017 Exactly IMG_WIDTH*IMG_HEIGHT output beats per frame, in raster order, one per pixel position.
REQ-018 Kernels: Gx = (p[x+1] column weighted 1,2,1) - (p[x-1] column weighted 1,2,1); Gy = the same weighting applied to row y+1 minus row y-1. Both are signed, PIX_W+4 bits.
REQ-019 Magnitude = |Gx|+|Gy|, saturated to 2^PIX_W-1.
REQ-020 Border positions (x==0, x==IMG_WIDTH-1, y==0, y==IMG_HEIGHT-1) output magnitude 0 and edge 0.
REQ-021 Two line buffers of IMG_WIDTH x PIX_W plus a 3x3 window register supply the neighbourhood.
REQ-022 FSM states: FILL, RUN, FLUSH.
REQ-023 FILL: accept pixels with no output until IMG_WIDTH+1 pixels are accepted, then go to RUN.
REQ-024 RUN: each input transfer produces the output for position (input index - IMG_WIDTH - 1); the output is registered and valid on the next cycle.
REQ-025 FLUSH: entered after the last frame pixel is accepted; in_ready=0; the remaining IMG_WIDTH+1 outputs are generated one per out_ready cycle. After the out_eof transfer, return to FILL.
REQ-026 Backpressure: in_ready = (state != FLUSH) && (!out_valid || out_ready); out_* signals are held stable while out_valid && !out_ready.
REQ-027 in_ready is 1 in FILL regardless of out_ready; no pixel is dropped or duplicated under any valid/ready pattern.
REQ-028 Input and output x/y counters wrap at IMG_WIDTH-1 and IMG_HEIGHT-1; out_eol and out_eof are decoded from the output counters.

Reset
REQ-029 While rst_n==0 at a clock edge: state=FILL, counters=0, out_valid=0, out_edge=0, out_eol=0, out_eof=0, out_mag=0, in_ready=0.
REQ-030 in_ready goes to 1 in the first cycle after rst_n is sampled 1.
REQ-031 Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
REQ-032 Line-buffer contents are not reset.

Configuration
REQ-033 Macro SOBEL_MAG_OUT_EN defined: the out_mag port exists and carries the saturated magnitude.
REQ-034 Macro SOBEL_MAG_OUT_EN undefined: the out_mag port and its register are absent; out_edge behaviour is identical.

Structure
REQ-035 Package sobel_pkg holds the FSM state enum, the kernel weight constants, and the gradient-width constant GRAD_W = PIX_W+4.
REQ-036 One sub-module, sobel_linebuf: a single-port-per-side IMG_WIDTH-deep delay line, instantiated twice.

Verification
REQ-037 8x6 frame, all pixels 77, threshold 10 -> 48 beats, all out_edge=0; out_eol on x=7; out_eof on beat 48.
REQ-038 8x6 frame, columns 0-3 = 0 and columns 4-7 = 200, threshold 100 -> out_edge=1 exactly at x=3,4 for y=1..4; out_mag=255 there.
REQ-039 Same image with threshold 255 -> no out_edge=1; the magnitude 255 saturation is visible on out_mag.
REQ-040 Random in_valid and out_ready (50% each) on the 8x6 step image -> output sequence identical to REQ-038, and out_* stable while stalled.
REQ-041 Assert rst_n=0 for 1 cycle after 20 pixels, then send a full 8x6 frame -> exactly 48 beats, matching the clean run.
REQ-042 Two back-to-back frames with threshold changed mid-frame -> the new threshold applies only from the second frame.
